// File: rtl/phibin_conv_arbiter.sv
// Round-robin front end sharing one fixed-latency relphi_to_phibin converter between N_REQ
// requesters, with tag matching and a credit-guarded show-ahead result FIFO. Option: PHIBIN_WRAP_EN.
module phibin_conv_arbiter #(
    parameter int N_REQ      = 4,
    parameter int CONV_LAT   = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int NPHI       = 27,
    localparam int IDW       = $clog2(N_REQ),
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int IW        = AW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [12*N_REQ-1:0]    req_rel_phi,
    input  logic [5*N_REQ-1:0]     req_start_phi,
    output logic [11:0]            conv_rel_phi,
    output logic [4:0]             conv_start_phi,
    input  logic [4:0]             conv_phi_bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_phi_bin,
    output logic [IDW-1:0]         out_req_id,
    output logic [IW-1:0]          inflight
);

    localparam int TAGS = CONV_LAT + 1;
    localparam int SW   = IDW + 1;

    generate
        if (N_REQ < 2 || N_REQ > 8 || FIFO_DEPTH < CONV_LAT + 1 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || NPHI < 1 || NPHI > 31) begin : g_bad_params
            $error("phibin_conv_arbiter: illegal parameter combination");
        end
    endgenerate

    logic [11:0] rel_arr [N_REQ];
    logic [4:0]  st_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign rel_arr[gi] = req_rel_phi[12*gi +: 12];
            assign st_arr[gi]  = req_start_phi[5*gi +: 5];
        end
    endgenerate

    logic [IDW-1:0]            ptr_q, ptr_d;
    logic [IW-1:0]             inflight_q, inflight_d;
    logic [11:0]               conv_rel_q;
    logic [4:0]                conv_st_q;
    logic [TAGS-1:0]           tag_vld_q;
    logic [TAGS-1:0][IDW-1:0]  tag_id_q;
    logic [4+IDW:0]            mem [FIFO_DEPTH];
    logic [AW:0]               wr_ptr_q, rd_ptr_q;

    logic                      can_issue;
    logic [N_REQ-1:0]          grant;
    logic [IDW-1:0]            grant_id;
    logic                      found;
    logic [SW-1:0]             scan;
    logic                      transfer;
    logic                      push;
    logic                      pop;
    logic [4:0]                wr_phi;

    // Credit counts every tag still in the pipe, so a non-stallable result always finds a slot.
    assign can_issue = (inflight_q < IW'(FIFO_DEPTH)) && !reset;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        scan     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            scan = {1'b0, ptr_q} + SW'(off);
            if (scan >= SW'(N_REQ)) begin
                scan = scan - SW'(N_REQ);
            end
            if (can_issue && !found && req_valid[scan[IDW-1:0]]) begin
                found                 = 1'b1;
                grant[scan[IDW-1:0]]  = 1'b1;
                grant_id              = scan[IDW-1:0];
            end
        end
    end

    assign req_ready = grant;
    assign transfer  = |grant;
    assign ptr_d     = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            conv_rel_q <= '0;
            conv_st_q  <= '0;
        end else if (transfer) begin
            ptr_q      <= ptr_d;
            conv_rel_q <= rel_arr[grant_id];
            conv_st_q  <= st_arr[grant_id];
        end
    end

    assign conv_rel_phi   = conv_rel_q;
    assign conv_start_phi = conv_st_q;

    // The tail tag lines up with the converter output one cycle after its last internal stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[TAGS-2:0], transfer};
        end
        tag_id_q <= {tag_id_q[TAGS-2:0], grant_id};
    end

`ifdef PHIBIN_WRAP_EN
    assign wr_phi = (conv_phi_bin >= 5'(NPHI)) ? conv_phi_bin - 5'(NPHI) : conv_phi_bin;
`else
    assign wr_phi = conv_phi_bin;
`endif

    assign push      = tag_vld_q[TAGS-1];
    assign out_valid = (wr_ptr_q != rd_ptr_q);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {wr_phi, tag_id_q[TAGS-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign out_phi_bin = out_valid ? mem[rd_ptr_q[AW-1:0]][4+IDW:IDW] : '0;
    assign out_req_id  = out_valid ? mem[rd_ptr_q[AW-1:0]][IDW-1:0]   : '0;

    always_comb begin
        inflight_d = inflight_q;
        case ({transfer, pop})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;

endmodule

// File: tb/tb_phibin_conv_arbiter.sv
// Directed bench for phibin_conv_arbiter: a 3-stage converter model, a cycle-accurate
// expectation queue checked every cycle, a table of arbitration vectors and corner sequences.
module tb_phibin_conv_arbiter;

    localparam int N_REQ      = 4;
    localparam int CONV_LAT   = 3;
    localparam int FIFO_DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [47:0] req_rel_phi;
    logic [19:0] req_start_phi;
    logic [11:0] conv_rel_phi;
    logic [4:0]  conv_start_phi;
    logic [4:0]  conv_phi_bin;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_phi_bin;
    logic [1:0]  out_req_id;
    logic [3:0]  inflight;

    logic [11:0] rel_d [4];
    logic [4:0]  st_d  [4];

    assign req_rel_phi   = {rel_d[3], rel_d[2], rel_d[1], rel_d[0]};
    assign req_start_phi = {st_d[3], st_d[2], st_d[1], st_d[0]};

    phibin_conv_arbiter #(
        .N_REQ(N_REQ), .CONV_LAT(CONV_LAT), .FIFO_DEPTH(FIFO_DEPTH), .NPHI(27)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rel_phi(req_rel_phi), .req_start_phi(req_start_phi),
        .conv_rel_phi(conv_rel_phi), .conv_start_phi(conv_start_phi),
        .conv_phi_bin(conv_phi_bin), .out_valid(out_valid), .out_ready(out_ready),
        .out_phi_bin(out_phi_bin), .out_req_id(out_req_id), .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] conv_f(input logic [11:0] r, input logic [4:0] s);
        return s + {1'b0, r[11:8]};
    endfunction

    function automatic logic [4:0] wrapv(input logic [4:0] v);
`ifdef PHIBIN_WRAP_EN
        return (v >= 5'd27) ? v - 5'd27 : v;
`else
        return v;
`endif
    endfunction

    // Converter stand-in: three register stages from conv_* to conv_phi_bin.
    logic [4:0] cs1, cs2, cs3;
    always @(posedge clk) begin
        cs1 <= conv_f(conv_rel_phi, conv_start_phi);
        cs2 <= cs1;
        cs3 <= cs2;
    end
    assign conv_phi_bin = cs3;

    typedef struct {
        logic [4:0] phi;
        logic [1:0] id;
        int         avail;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } vec_t;

    exp_t        mq[$];
    int          mptr;
    logic [11:0] mconv_rel;
    logic [4:0]  mconv_st;
    int          cyc;
    int          grants;
    logic [4:0]  last_phi;
    int          errors;
    int          checks;
    vec_t        tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] model_grant(input logic [3:0] v, input int p, input logic can);
        logic [3:0] g;
        logic       hit;
        g   = '0;
        hit = 1'b0;
        if (can) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (p + k) % 4;
                if (!hit && v[i]) begin
                    g[i] = 1'b1;
                    hit  = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // One clock: compare against the model, advance the model, step to the next negedge.
    task automatic cycle(input bit en);
        logic [3:0] eg;
        logic       can;
        logic       mvalid;
        int         gid;
        #1;
        can    = (mq.size() < FIFO_DEPTH) && !reset;
        eg     = model_grant(req_valid, mptr, can);
        mvalid = (mq.size() > 0) && (mq[0].avail <= cyc);
        if (en) begin
            chk("req_ready", req_ready, eg);
            chk("out_valid", out_valid, mvalid);
            if (mvalid) begin
                chk("out_phi_bin", out_phi_bin, mq[0].phi);
                chk("out_req_id", out_req_id, mq[0].id);
            end
            chk("inflight", inflight, mq.size());
            chk("conv_rel_phi", conv_rel_phi, mconv_rel);
            chk("conv_start_phi", conv_start_phi, mconv_st);
        end
        if (req_ready != 4'b0) grants++;
        if (reset) begin
            mq.delete();
            mptr      = 0;
            mconv_rel = '0;
            mconv_st  = '0;
        end else begin
            if (mvalid && out_ready) begin
                $display("pop  id=%0d phi=%0d cycle=%0d", mq[0].id, mq[0].phi, cyc);
                last_phi = mq[0].phi;
                void'(mq.pop_front());
            end
            if (eg != 4'b0) begin
                gid = 0;
                for (int k = 0; k < 4; k++) if (eg[k]) gid = k;
                mq.push_back('{wrapv(conv_f(rel_d[gid], st_d[gid])), 2'(gid), cyc + 5});
                mconv_rel = rel_d[gid];
                mconv_st  = st_d[gid];
                mptr      = (gid + 1) % 4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; mptr = 0; grants = 0; last_phi = '0;
        mconv_rel = '0; mconv_st = '0;
        rel_d[0] = 12'h213; st_d[0] = 5'd1;
        rel_d[1] = 12'h345; st_d[1] = 5'd2;
        rel_d[2] = 12'h100; st_d[2] = 5'd5;
        rel_d[3] = 12'h5a0; st_d[3] = 5'd9;
        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0100};
        tbl[2]  = '{4'b0101, 4'b0001};
        tbl[3]  = '{4'b1111, 4'b0010};
        tbl[4]  = '{4'b1001, 4'b1000};
        tbl[5]  = '{4'b1010, 4'b0010};
        tbl[6]  = '{4'b0011, 4'b0001};
        tbl[7]  = '{4'b0001, 4'b0001};
        tbl[8]  = '{4'b1110, 4'b0010};
        tbl[9]  = '{4'b0000, 4'b0000};
        tbl[10] = '{4'b0010, 4'b0010};
        reset = 1'b1; req_valid = '0; out_ready = 1'b1;
        @(negedge clk);

        // Reset state
        cycle(0);
        cycle(1);
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_phi_bin", out_phi_bin, 0);
        chk("rst_out_req_id", out_req_id, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_conv_rel", conv_rel_phi, 0);

        // Single request from requester 2
        req_valid = 4'b0100;
        #1 chk("single_ready", req_ready, 4'b0100);
        cycle(1);
        req_valid = 4'b0000;
        chk("single_conv_rel", conv_rel_phi, 12'h100);
        repeat (3) cycle(1);
        chk("single_not_yet", out_valid, 0);
        cycle(1);
        chk("single_valid", out_valid, 1);
        chk("single_phi", out_phi_bin, 6);
        chk("single_id", out_req_id, 2);
        repeat (4) cycle(1);

        // Arbitration table from a fresh pointer
        reset = 1'b1; cycle(1); reset = 1'b0;
        for (int k = 0; k < 11; k++) begin
            req_valid = tbl[k].valid;
            #1 chk("tbl_ready", req_ready, tbl[k].exp_ready);
            cycle(1);
        end
        req_valid = '0;
        repeat (8) cycle(1);

        // Continuous round robin
        reset = 1'b1; cycle(1); reset = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            #1 chk("rr_grant", req_ready, 4'b0001 << (k % 4));
            cycle(1);
        end
        req_valid = '0;
        repeat (8) cycle(1);

        // Backpressure: credit limit, then one pop buys one grant
        reset = 1'b1; cycle(1); reset = 1'b0;
        out_ready = 1'b0; req_valid = 4'b1111; grants = 0;
        repeat (14) cycle(1);
        chk("bp_grants", grants, 8);
        chk("bp_inflight", inflight, 8);
        grants = 0;
        out_ready = 1'b1; cycle(1); out_ready = 1'b0;
        repeat (8) cycle(1);
        chk("bp_pulse_grants", grants, 1);

        // Full FIFO drained while requests keep coming
        out_ready = 1'b1;
        repeat (20) cycle(1);
        req_valid = '0;
        repeat (14) cycle(1);
        chk("drain_valid", out_valid, 0);
        chk("drain_inflight", inflight, 0);

        // Reset with conversions in flight
        req_valid = 4'b1111;
        repeat (3) cycle(1);
        req_valid = '0;
        reset = 1'b1; cycle(1); reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_inflight", inflight, 0);
        repeat (8) cycle(1);
        req_valid = 4'b1111;
        #1 chk("post_rst_prio", req_ready, 4'b0001);
        cycle(1);
        req_valid = '0;
        repeat (8) cycle(1);

        // Converter result beyond the last phi bin
        rel_d[1] = 12'h800; st_d[1] = 5'd20;
        req_valid = 4'b0010;
        cycle(1);
        req_valid = '0;
        repeat (8) cycle(1);
`ifdef PHIBIN_WRAP_EN
        chk("wrap_phi", last_phi, 1);
`else
        chk("wrap_phi", last_phi, 28);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
